// File: rtl/fpu_pipe.sv
// fpu_pipe: three-stage pipelined add/sub/mul for a parameterised IEEE-like format.
// Results are truncated, denormal inputs are read as zero, and one global stall holds every stage.
module fpu_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_vld,
  output logic                   o_rdy,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  input  logic [3:0]             opcode,
  output logic [EXP_W+MAN_W:0]   o_res,
  output logic                   o_res_vld,
  input  logic                   i_rdy,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;          // signed working exponent
  localparam int GW = MAN_W + 2;          // hidden bit + fraction + guard bit
  localparam int PW = 2 * MAN_W + 2;      // product width, shared by the normaliser
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [3:0] OP_ADD = 4'b1110;
  localparam logic [3:0] OP_MUL = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1101;

  typedef enum logic [2:0] {K_ADD, K_MUL, K_ZERO, K_NAN, K_ILL} kind_e;

  logic                 s1_vld_d, s1_vld_q;
  kind_e                s1_kind_d, s1_kind_q;
  logic                 s1_sign_d, s1_sign_q;
  logic                 s1_eff_sub_d, s1_eff_sub_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q;
  logic [GW-1:0]        s1_ma_d, s1_ma_q;
  logic [GW-1:0]        s1_mb_d, s1_mb_q;

  logic                 s2_vld_d, s2_vld_q;
  kind_e                s2_kind_d, s2_kind_q;
  logic                 s2_sign_d, s2_sign_q;
  logic signed [EW-1:0] s2_exp_d, s2_exp_q;
  logic [PW-1:0]        s2_man_d, s2_man_q;

  logic                 res_vld_d, res_vld_q;
  logic [W-1:0]         res_d, res_q;
  logic                 ovf_d, ovf_q, unf_d, unf_q, inv_d, inv_q;

  logic advance;

  assign o_rdy   = !res_vld_q || i_rdy;
  assign advance = o_rdy;

  // Stage 1: unpack, order add operands by magnitude and align, or add mul exponents.
  logic [EXP_W-1:0] ea, eb, e_big, e_small;
  logic [MAN_W:0]   ma, mb;
  logic [GW-1:0]    m_big, m_small;
  logic             sa, sb, is_add, is_sub, is_mul, a_big;

  always_comb begin
    ea      = i_a[W-2 -: EXP_W];
    eb      = i_b[W-2 -: EXP_W];
    ma      = (ea == '0) ? '0 : {1'b1, i_a[MAN_W-1:0]};
    mb      = (eb == '0) ? '0 : {1'b1, i_b[MAN_W-1:0]};
    is_add  = (opcode == OP_ADD);
    is_sub  = (opcode == OP_SUB);
    is_mul  = (opcode == OP_MUL);
    sa      = i_a[W-1];
    sb      = i_b[W-1] ^ is_sub;
    a_big   = {ea, ma} >= {eb, mb};
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? {ma, 1'b0} : {mb, 1'b0};
    m_small = a_big ? {mb, 1'b0} : {ma, 1'b0};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    s1_vld_d     = s1_vld_q;
    s1_kind_d    = s1_kind_q;
    s1_sign_d    = s1_sign_q;
    s1_eff_sub_d = s1_eff_sub_q;
    s1_exp_d     = s1_exp_q;
    s1_ma_d      = s1_ma_q;
    s1_mb_d      = s1_mb_q;
    if (advance) begin
      s1_vld_d     = i_vld;
      s1_kind_d    = K_ADD;
      s1_sign_d    = a_big ? sa : sb;
      s1_eff_sub_d = sa ^ sb;
      s1_exp_d     = EW'(e_big);
      s1_ma_d      = m_big;
      s1_mb_d      = m_small >> (e_big - e_small);
      if (!(is_add || is_sub || is_mul)) begin
        s1_kind_d = K_ILL;
      end else if ((&ea) || (&eb)) begin
        s1_kind_d = K_NAN;
      end else if (is_mul) begin
        s1_kind_d = ((ea == '0) || (eb == '0)) ? K_ZERO : K_MUL;
        s1_sign_d = sa ^ i_b[W-1];
        s1_exp_d  = EW'(ea) + EW'(eb) - BIAS;
        s1_ma_d   = {1'b0, ma};
        s1_mb_d   = {1'b0, mb};
      end
    end
  end

  // Stage 2: mantissa add/subtract or multiply, landed with the hidden bit at PW-2.
  logic [GW:0]   sum;
  logic [PW-1:0] prod;

  always_comb begin
    sum  = s1_eff_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                        : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});
    prod = PW'(s1_ma_q[MAN_W:0]) * PW'(s1_mb_q[MAN_W:0]);

    s2_vld_d  = s2_vld_q;
    s2_kind_d = s2_kind_q;
    s2_sign_d = s2_sign_q;
    s2_exp_d  = s2_exp_q;
    s2_man_d  = s2_man_q;
    if (advance) begin
      s2_vld_d  = s1_vld_q;
      s2_kind_d = s1_kind_q;
      s2_sign_d = s1_sign_q;
      s2_exp_d  = s1_exp_q;
      s2_man_d  = (s1_kind_q == K_MUL) ? prod : (PW'(sum) << (MAN_W - 1));
    end
  end

  // Stage 3: normalise (one-bit right shift on carry, else left by leading zeros) and pack.
  int                   lz;
  logic [PW-1:0]        shifted;
  logic signed [EW-1:0] exp_n;
  logic [MAN_W-1:0]     frac;

  always_comb begin
    lz = 0;
    for (int i = 0; i <= PW - 2; i++) begin
      if (s2_man_q[i]) lz = PW - 2 - i;
    end
    shifted = s2_man_q << lz;
    if (s2_man_q[PW-1]) begin
      exp_n = s2_exp_q + EW'(1);
      frac  = MAN_W'(s2_man_q >> (PW - 1 - MAN_W));
    end else begin
      exp_n = s2_exp_q - EW'(lz);
      frac  = MAN_W'(shifted >> (PW - 2 - MAN_W));
    end

    res_vld_d = res_vld_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inv_d     = inv_q;
    if (advance) begin
      res_vld_d = s2_vld_q;
      res_d     = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      inv_d     = 1'b0;
      if (s2_vld_q) begin
        unique case (s2_kind_q)
          K_ILL:  inv_d = 1'b1;
          K_NAN: begin
            res_d = CANON_NAN;
            inv_d = 1'b1;
          end
          K_ZERO: res_d = {s2_sign_q, {(W-1){1'b0}}};
          default: begin
            // A zero sum is always +0, whatever the operand signs were.
            if (s2_man_q == '0) begin
              res_d = '0;
            end else if (exp_n >= EMAX) begin
              res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              ovf_d = 1'b1;
            end else if (exp_n <= 0) begin
              res_d = {s2_sign_q, {(W-1){1'b0}}};
              unf_d = 1'b1;
            end else begin
              res_d = {s2_sign_q, EXP_W'(exp_n), frac};
            end
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_kind_q    <= K_ADD;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_exp_q     <= '0;
      s1_ma_q      <= '0;
      s1_mb_q      <= '0;
      s2_vld_q     <= 1'b0;
      s2_kind_q    <= K_ADD;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_man_q     <= '0;
      res_vld_q    <= 1'b0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_kind_q    <= s1_kind_d;
      s1_sign_q    <= s1_sign_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_exp_q     <= s1_exp_d;
      s1_ma_q      <= s1_ma_d;
      s1_mb_q      <= s1_mb_d;
      s2_vld_q     <= s2_vld_d;
      s2_kind_q    <= s2_kind_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_man_q     <= s2_man_d;
      res_vld_q    <= res_vld_d;
      res_q        <= res_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      inv_q        <= inv_d;
    end
  end

  assign o_res     = res_q;
  assign o_res_vld = res_vld_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fpu_pipe.sv
// tb_fpu_pipe: directed and randomised checks of fpu_pipe (half precision) against an
// arithmetic reference model and scoreboard, plus one single-precision build.
module tb_fpu_pipe;
  localparam logic [3:0] OP_ADD = 4'b1110;
  localparam logic [3:0] OP_MUL = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1101;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_vld = 1'b0, i_rdy = 1'b0, o_rdy, o_res_vld;
  logic        overflow, underflow, invalid;
  logic [15:0] i_a = '0, i_b = '0, o_res;
  logic [3:0]  opcode = '0;

  logic        w_vld = 1'b0, w_rdy_in = 1'b1, w_rdy, w_res_vld, w_ovf, w_unf, w_inv;
  logic [31:0] w_a = '0, w_b = '0, w_res;
  logic [3:0]  w_op = '0;

  int checks = 0, errors = 0, delivered = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
  } stim_t;

  stim_t       stim_q[$];
  logic [18:0] exp_q[$];   // {overflow, underflow, invalid, result}

  always #5 i_clk = ~i_clk;

  fpu_pipe u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_a(i_a), .i_b(i_b), .opcode(opcode), .o_res(o_res), .o_res_vld(o_res_vld),
    .i_rdy(i_rdy), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fpu_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(w_vld), .o_rdy(w_rdy),
    .i_a(w_a), .i_b(w_b), .opcode(w_op), .o_res(w_res), .o_res_vld(w_res_vld),
    .i_rdy(w_rdy_in), .overflow(w_ovf), .underflow(w_unf), .invalid(w_inv)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] pack(input int sgn, input int e, input longint m);
    if (e >= 31) return {3'b100, sgn[0], 5'h1F, 10'h000};
    if (e <= 0)  return {3'b010, sgn[0], 15'h0000};
    return {3'b000, sgn[0], e[4:0], m[9:0]};
  endfunction

  // Value of a normal operand is m * 2^(e-25) with m = 1024 + fraction.
  function automatic logic [18:0] model(input stim_t s);
    int ea, eb, sa, sb, e, sgn, t;
    longint ma, mb, r, tm;
    if (s.op != OP_ADD && s.op != OP_SUB && s.op != OP_MUL) return {3'b001, 16'h0000};
    ea = int'(s.a[14:10]);
    eb = int'(s.b[14:10]);
    if (ea == 31 || eb == 31) return {3'b001, 16'h7E00};
    sa = int'(s.a[15]);
    sb = int'(s.b[15]);
    ma = (ea == 0) ? 0 : 1024 + longint'(s.a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + longint'(s.b[9:0]);
    if (s.op == OP_MUL) begin
      sgn = sa ^ sb;
      if (ma == 0 || mb == 0) return {3'b000, sgn[0], 15'h0000};
      r = ma * mb;
      e = ea + eb - 15;
      if (r >= 2097152) begin r = r >> 1; e++; end
      return pack(sgn, e, r >> 10);
    end
    if (s.op == OP_SUB) sb = sb ^ 1;
    if (eb * 2048 + mb > ea * 2048 + ma) begin
      t = ea; ea = eb; eb = t;
      t = sa; sa = sb; sb = t;
      tm = ma; ma = mb; mb = tm;
    end
    // Smaller operand keeps one bit below the larger one's LSB; the rest is dropped.
    r = (sa == sb) ? (ma * 2 + ((mb * 2) >> (ea - eb))) : (ma * 2 - ((mb * 2) >> (ea - eb)));
    if (r == 0) return 19'h0;
    e = ea;
    while (r >= 4096) begin r = r >> 1; e++; end
    while (r < 2048) begin r = r << 1; e--; end
    return pack(sa, e, r >> 1);
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [4:0] e;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = 5'd0;
      1:       e = 5'd31;
      2:       e = 5'd30;
      3:       e = 5'd1;
      default: e = 5'($urandom_range(8, 22));
    endcase
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int k;
    s.a = rand_fp();
    s.b = rand_fp();
    k = $urandom_range(0, 15);
    s.op = (k < 5) ? OP_ADD : (k < 10) ? OP_SUB : (k < 14) ? OP_MUL : 4'($urandom);
    if ($urandom_range(0, 9) == 0) s.b = s.a;
    return s;
  endfunction

  // One clock: drive at negedge, sample 1ns later, score the handshakes due at the next posedge.
  task automatic drive_cycle(input logic rdy, input logic offer, output logic saw_rdy);
    @(negedge i_clk);
    i_rdy = rdy;
    if (offer && stim_q.size() > 0) begin
      i_vld  = 1'b1;
      i_a    = stim_q[0].a;
      i_b    = stim_q[0].b;
      opcode = stim_q[0].op;
    end else begin
      i_vld = 1'b0;
    end
    #1;
    saw_rdy = o_rdy;
    if (o_res_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious", o_res_vld, 0);
      end else begin
        check("res", {overflow, underflow, invalid, o_res}, exp_q[0]);
        if (i_rdy) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
    if (i_vld && o_rdy) begin
      exp_q.push_back(model(stim_q[0]));
      void'(stim_q.pop_front());
    end
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [18:0] exp);
    int lat;
    @(negedge i_clk);
    i_a = a; i_b = b; opcode = op; i_vld = 1'b1; i_rdy = 1'b1;
    #1 check({tag, "_rdy"}, o_rdy, 1);
    @(posedge i_clk);
    #1 i_vld = 1'b0;
    lat = 1;
    while (!o_res_vld && lat < 8) begin
      @(posedge i_clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check(tag, {overflow, underflow, invalid, o_res}, exp);
    @(posedge i_clk);
    #1 check({tag, "_drain"}, o_res_vld, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int lat, d0;

    repeat (3) @(negedge i_clk);
    #1;
    check("rst_vld", o_res_vld, 0);
    check("rst_out", {overflow, underflow, invalid, o_res}, 0);
    check("rst_rdy", o_rdy, 1);
    #1 i_rst_n = 1'b1;

    single("add_1p1",  16'h3C00, 16'h3C00, OP_ADD, {3'b000, 16'h4000});
    single("mul_3",    16'h3E00, 16'h4000, OP_MUL, {3'b000, 16'h4200});
    single("sub_zero", 16'h3C00, 16'h3C00, OP_SUB, {3'b000, 16'h0000});
    single("mul_ovf",  16'h7BFF, 16'h4000, OP_MUL, {3'b100, 16'h7C00});
    single("mul_unf",  16'h0400, 16'h0400, OP_MUL, {3'b010, 16'h0000});
    single("add_nan",  16'h7C00, 16'h3C00, OP_ADD, {3'b001, 16'h7E00});
    single("illegal",  16'h3C00, 16'h3C00, 4'b0000, {3'b001, 16'h0000});

    // Four back-to-back adds, downstream stalls for two cycles once the first result is up.
    stim_q.push_back('{a: 16'h3C00, b: 16'h3C00, op: OP_ADD});
    stim_q.push_back('{a: 16'h4000, b: 16'h3800, op: OP_ADD});
    stim_q.push_back('{a: 16'h4500, b: 16'hC100, op: OP_ADD});
    stim_q.push_back('{a: 16'h3555, b: 16'h1234, op: OP_ADD});
    d0 = delivered;
    repeat (3) drive_cycle(1'b1, 1'b1, r);
    repeat (2) begin
      drive_cycle(1'b0, 1'b1, r);
      check("stall_rdy", r, 0);
      check("stall_vld", o_res_vld, 1);
    end
    for (int c = 0; c < 50 && (stim_q.size() + exp_q.size()) != 0; c++) drive_cycle(1'b1, 1'b1, r);
    check("stall_cnt", delivered - d0, 4);

    // Reset while two operations are in flight and the first result is on the output.
    stim_q.push_back('{a: 16'h4200, b: 16'h3C00, op: OP_ADD});
    stim_q.push_back('{a: 16'h4200, b: 16'h4200, op: OP_MUL});
    drive_cycle(1'b1, 1'b1, r);
    drive_cycle(1'b1, 1'b1, r);
    drive_cycle(1'b1, 1'b0, r);
    drive_cycle(1'b0, 1'b0, r);
    check("pre_rst_vld", o_res_vld, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst2_vld", o_res_vld, 0);
    check("rst2_out", {overflow, underflow, invalid, o_res}, 0);
    check("rst2_rdy", o_rdy, 1);
    exp_q.delete();
    stim_q.delete();
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    repeat (6) begin
      drive_cycle(1'b1, 1'b0, r);
      check("no_stale", o_res_vld, 0);
    end
    stim_q.push_back('{a: 16'h3C00, b: 16'h4000, op: OP_SUB});
    d0 = delivered;
    for (int c = 0; c < 20 && (stim_q.size() + exp_q.size()) != 0; c++) drive_cycle(1'b1, 1'b1, r);
    check("post_rst_cnt", delivered - d0, 1);

    // Randomised traffic with random back-pressure and input gaps.
    for (int n = 0; n < 400; n++) stim_q.push_back(rand_stim());
    d0 = delivered;
    for (int c = 0; c < 5000 && (stim_q.size() + exp_q.size()) != 0; c++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, r);
    check("rand_drain", stim_q.size() + exp_q.size(), 0);
    check("rand_cnt", delivered - d0, 400);

    // Single-precision build.
    @(negedge i_clk);
    w_a = 32'h3FC00000; w_b = 32'h40000000; w_op = OP_MUL; w_vld = 1'b1;
    @(posedge i_clk);
    #1 w_vld = 1'b0;
    lat = 1;
    while (!w_res_vld && lat < 8) begin
      @(posedge i_clk);
      #1 lat++;
    end
    check("w32_lat", lat, 3);
    check("w32_mul", {w_ovf, w_unf, w_inv, w_res}, {3'b000, 32'h40400000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_pipe.md
FPU_PIPE -- requirements
Module: fpu_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width; W = 1+EXP_W+MAN_W, default 16 (IEEE half).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_vld  input  1  operand set valid.
REQ-006 SHALL have port o_rdy  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports i_a and i_b  input  W  operands {sign, exponent, mantissa}.
REQ-008 SHALL have port opcode  input  4  1110 add, 1111 mul, 1101 sub (a-b); others illegal.
REQ-009 SHALL have port o_res  output  W  result.
REQ-010 SHALL have port o_res_vld  output  1  result valid.
REQ-011 SHALL have port i_rdy  input  1  downstream accepts result.
REQ-012 SHALL have ports overflow, underflow, invalid  output  1 each  per-result flags, qualified by o_res_vld.

Function
REQ-013 SHALL accept a transfer when i_vld && o_rdy, capturing i_a, i_b, opcode.
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/align or exponent add, S2 mantissa add or multiply, S3 normalise/pack; o_res_vld rises 3 cycles after acceptance with no stall.
REQ-015 SHALL sustain one accepted operand set per cycle while i_rdy=1.
REQ-016 SHALL stall globally: o_rdy = !o_res_vld || i_rdy; on stall every stage holds.
REQ-017 SHALL hold o_res, flags, o_res_vld stable while o_res_vld=1 and i_rdy=0.
REQ-018 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-019 SHALL treat bubbles (stage valid=0) as don't-care data; only valid bits propagate.
REQ-020 SHALL treat inputs with exponent 0 as signed zero (denormals flushed).
REQ-021 SHALL output canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7E00 at default) with invalid=1 when either input has exponent all ones.
REQ-022 SHALL round toward zero (truncate) with one guard bit for alignment.
REQ-023 SHALL on exponent overflow output signed infinity (exponent all ones, mantissa 0) with overflow=1.
REQ-024 SHALL on exponent underflow output signed zero with underflow=1.
REQ-025 SHALL output +0 on exact cancellation in add/sub.
REQ-026 SHALL on illegal opcode output 0 with invalid=1, still consuming one pipeline slot.
REQ-027 SHALL compute sub as add with sign of i_b inverted at S1.
REQ-028 SHALL compute mul sign as XOR of signs; exponent = ea+eb-bias, bias = 2^(EXP_W-1)-1, computed with EXP_W+2 bits signed.
REQ-029 SHALL register all outputs except o_rdy, which is combinational from o_res_vld and i_rdy.

Reset
REQ-030 SHALL on i_rst_n=0 immediately clear all stage valids, o_res_vld=0, o_res=0, all flags 0, regardless of clock.
REQ-031 SHALL discard in-flight operations on reset; first result after release comes only from operands accepted after release.
REQ-032 SHALL drive o_rdy=1 during and after reset (i_rdy irrelevant while o_res_vld=0).

Verification
REQ-033 SHALL pass: add 0x3C00+0x3C00 at cycle 0, i_rdy=1 -> cycle 3 o_res=0x4000, o_res_vld=1, all flags 0.
REQ-034 SHALL pass: mul 0x3E00*0x4000 -> o_res=0x4200; sub 0x3C00-0x3C00 -> o_res=0x0000; mul 0x7BFF*0x4000 -> 0x7C00, overflow=1.
REQ-035 SHALL pass: mul 0x0400*0x0400 -> 0x0000, underflow=1; add 0x7C00+0x3C00 -> 0x7E00, invalid=1; opcode 0000 -> 0x0000, invalid=1.
REQ-036 SHALL pass: 4 back-to-back adds, i_rdy=0 for 2 cycles once first result valid -> o_rdy=0 those cycles, outputs held, all 4 results delivered in order.
REQ-037 SHALL pass: reset asserted 1 cycle after accepting 2 ops -> o_res_vld=0 at once; after release, no stale result appears.
REQ-038 SHALL pass: EXP_W=8, MAN_W=23 build, mul 0x3FC00000*0x40000000 -> 0x40400000 after 3 cycles.
